max_pool_2x2: RTL and testbench
===============================

// Module: max_pool_2x2
// PURPOSE
//  Downstream consumer of the ReLU activation stage: 2x2, stride-2 max pooling on a raster-order
//  feature-map stream (row-major, one pixel per valid cycle, no backpressure). A half-width line
//  buffer holds horizontal pair maxima of even rows; on odd rows each completed window emits one
//  pooled pixel. Output feeds the next conv layer / flatten stage with the same valid-strobe protocol.
// PARAMETERS
//  DATA_W   20  pixel width; equals ReLU output width (dataWidth+4), unsigned (ReLU output MSB is 0)
//  IMG_W    24  input feature-map width in pixels; must be even, >=2
//  IMG_H    24  input feature-map height in rows; must be even, >=2
// PORTS
//  clk                  in   1       single clock, all state on posedge
//  rst                  in   1       asynchronous, active-high reset
//  pool_data_valid_In   in   1       qualifies pool_Input this cycle
//  pool_Input           in   DATA_W  activation pixel, unsigned
//  pool_data_valid_Out  out  1       one-cycle strobe, out holds a pooled pixel
//  out                  out  DATA_W  pooled pixel (max of 2x2 window)
//  frame_done           out  1       one-cycle strobe coincident with last pooled pixel of a frame
// BEHAVIOUR
//  - Reset (async assert, sync release): col_cnt=0, row_cnt=0, hold=0, pool_data_valid_Out=0,
//    out=0, frame_done=0. Line buffer contents are not reset (always written before read).
//  - Counters advance only on pool_data_valid_In=1; col_cnt 0..IMG_W-1 wraps to 0 and increments
//    row_cnt; row_cnt 0..IMG_H-1 wraps to 0 (next frame starts with no idle cycle required).
//  - Even col: hold <= pool_Input. Odd col: hmax = max(hold, pool_Input) (combinational).
//  - Even row, odd col: lb[col_cnt>>1] <= hmax. No output.
//  - Odd row, odd col: out <= max(hmax, lb[col_cnt>>1]); pool_data_valid_Out <= 1.
//  - Latency: out/valid register 1 cycle after the input sample completing the window.
//  - Comparisons are unsigned, full DATA_W; no arithmetic, no width growth. Ties: value identical.
//  - When no output is produced, pool_data_valid_Out <= 0 and out holds its last value.
//  - frame_done <= 1 in the same cycle as the pooled pixel from input (IMG_H-1, IMG_W-1), else 0.
//  - Gaps in pool_data_valid_In of any length are legal; state holds, no timeout.
//  - Output rate: IMG_W/2 pixels per odd row, (IMG_W/2)*(IMG_H/2) per frame.
//  - Reset mid-frame: partial frame is discarded; first valid after release is pixel (0,0).
//  - Line buffer read and write never address the same entry in the same cycle (write on even
//    rows only, read on odd rows only): no bypass logic needed.
//  - Elaboration check: IMG_W or IMG_H odd -> $error at elaboration; no runtime handling.
// STRUCTURE
//  - Shared package/header cnn_params: DATA_W (derived from dataWidth+4), IMG_W, IMG_H per layer,
//    so ReLU, pool and next-layer widths cannot diverge.
//  - One sub-module: max_pool_line_buffer (IMG_W/2 x DATA_W, 1 write port, 1 async read port,
//    register array; no reset). Counters, hold register, comparators, output regs in top.
// TESTING (IMG_W=4, IMG_H=4 unless stated)
//  1 Rows [1,5,2,3],[4,0,7,6],[9,9,0,0],[8,10,0,1], contiguous valid -> out 5,7,10,1; valid
//    strobes 1 cycle after input indices 5,7,13,15; frame_done only with the 1.
//  2 Same frame, valid low for 3 cycles between every sample -> identical values, each strobe
//    1 cycle after its completing sample, no extra/missing strobes.
//  3 All pixels 20'h7FFFF (ReLU saturation) except one 0 per window -> out 20'h7FFFF x4.
//  4 Two frames back-to-back (frame B = frame A +1) -> 5,7,10,1 then 6,8,11,2; two frame_done.
//  5 Assert rst after 6 samples of frame A, release, send full frame A -> valid/out/frame_done go
//    0 immediately on assert; afterwards exactly 5,7,10,1, nothing from the aborted frame.
//  6 Default 24x24, random 19-bit data vs reference model -> 144 outputs match, 1 frame_done.

Source files
------------

// File: rtl/max_pool_2x2_pkg.sv
// Shared layer parameters for the ReLU -> pool -> next-layer chain, so the
// stages cannot disagree on pixel width or feature-map geometry.
package max_pool_2x2_pkg;

  localparam int DATAWIDTH = 16;
  localparam int DATA_W    = DATAWIDTH + 4;
  localparam int IMG_W     = 24;
  localparam int IMG_H     = 24;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_pool_line_buffer.sv
// Half-width line buffer: one write port, one combinational read port.
// Contents are not reset; every entry is written on an even row before it is read.
module max_pool_line_buffer
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W = max_pool_2x2_pkg::DATA_W,
  parameter int DEPTH  = max_pool_2x2_pkg::IMG_W / 2,
  parameter int AW     = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling on a raster-order pixel stream with a valid strobe.
// Even rows store horizontal pair maxima; odd rows emit one pooled pixel per window.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W = max_pool_2x2_pkg::DATA_W,
  parameter int IMG_W  = max_pool_2x2_pkg::IMG_W,
  parameter int IMG_H  = max_pool_2x2_pkg::IMG_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pool_data_valid_In,
  input  logic [DATA_W-1:0] pool_Input,
  output logic              pool_data_valid_Out,
  output logic [DATA_W-1:0] out,
  output logic              frame_done
);

  localparam int CW = clog2_min1(IMG_W);
  localparam int RW = clog2_min1(IMG_H);
  localparam int AW = clog2_min1(IMG_W / 2);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $error("max_pool_2x2: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $error("max_pool_2x2: IMG_H must be even and >= 2");
  end

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] hmax;
  logic [DATA_W-1:0] pooled;
  logic [DATA_W-1:0] lb_rdata;
  logic [AW-1:0]     lb_addr;
  logic              lb_we;

  // Write (even rows) and read (odd rows) never coincide, so one address serves both.
  assign lb_addr = AW'(col_q >> 1);
  assign hmax    = (hold_q > pool_Input) ? hold_q : pool_Input;
  assign pooled  = (hmax > lb_rdata) ? hmax : lb_rdata;

  max_pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W / 2),
    .AW     (AW)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    lb_we   = 1'b0;
    if (pool_data_valid_In) begin
      if (!col_q[0]) begin
        hold_d = pool_Input;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        valid_d = 1'b1;
        out_d   = pooled;
        done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign pool_data_valid_Out = valid_q;
  assign out                 = out_q;
  assign frame_done          = done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed + randomized bench for max_pool_2x2: a 4x4 instance for the directed
// frames and a default 24x24 instance for the random frame, both against a window model.
module tb_max_pool_2x2;
  import max_pool_2x2_pkg::*;

  localparam int DW = max_pool_2x2_pkg::DATA_W;

  typedef struct packed {
    logic [DW-1:0] v;
    logic          d;
    int            c;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v4 = 1'b0, v24 = 1'b0;
  logic [DW-1:0] d4 = '0, d24 = '0;
  logic          vo4, vo24, fd4, fd24;
  logic [DW-1:0] o4, o24;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  ev_t mon4[$];
  ev_t mon24[$];
  ev_t expq[$];
  logic [DW-1:0] frm[$];

  max_pool_2x2 #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk (clk), .rst (rst),
    .pool_data_valid_In (v4), .pool_Input (d4),
    .pool_data_valid_Out (vo4), .out (o4), .frame_done (fd4)
  );

  max_pool_2x2 dut24 (
    .clk (clk), .rst (rst),
    .pool_data_valid_In (v24), .pool_Input (d24),
    .pool_data_valid_Out (vo24), .out (o24), .frame_done (fd24)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Any strobe on either output becomes an event; stray frame_done shows up as an extra event.
  always @(negedge clk) begin
    if (vo4 || fd4)   mon4.push_back('{v: o4, d: fd4, c: cyc});
    if (vo24 || fd24) mon24.push_back('{v: o24, d: fd24, c: cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input int idx, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    v4 = 1'b0;
    v24 = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Sends frm as one W x H frame, then appends the model's pooled outputs to expq.
  task automatic send_frame(input bit big, input int w, input int h, input int gap);
    int samp[$];
    logic [DW-1:0] m;
    for (int i = 0; i < w * h; i++) begin
      @(negedge clk);
      if (big) begin v24 = 1'b1; d24 = frm[i]; end
      else     begin v4  = 1'b1; d4  = frm[i]; end
      samp.push_back(cyc + 1);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        v4 = 1'b0;
        v24 = 1'b0;
      end
    end
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        m = mx(mx(frm[2*r*w + 2*c], frm[2*r*w + 2*c + 1]),
               mx(frm[(2*r+1)*w + 2*c], frm[(2*r+1)*w + 2*c + 1]));
        expq.push_back('{v: m, d: (r == h/2 - 1) && (c == w/2 - 1),
                         c: samp[(2*r+1)*w + 2*c + 1]});
      end
    end
  endtask

  task automatic check_stream(input bit big, input string tag);
    ev_t o;
    ev_t e;
    int  n_obs;
    int  n_min;
    n_obs = big ? mon24.size() : mon4.size();
    chk_val({tag, "_count"}, 0, n_obs, expq.size());
    n_min = (n_obs < expq.size()) ? n_obs : expq.size();
    for (int i = 0; i < n_min; i++) begin
      o = big ? mon24[i] : mon4[i];
      e = expq[i];
      $display("%s[%0d] out=%0h exp=%0h cyc=%0d exp_cyc=%0d done=%0b",
               tag, i, o.v, e.v, o.c, e.c, o.d);
      chk_val({tag, "_out"}, i, int'(o.v), int'(e.v));
      chk_val({tag, "_cycle"}, i, o.c, e.c);
      chk_bit({tag, "_frame_done"}, o.d, e.d);
    end
    mon4.delete();
    mon24.delete();
    expq.delete();
  endtask

  task automatic load_f1(input int add);
    int f1[16];
    f1 = '{1, 5, 2, 3, 4, 0, 7, 6, 9, 9, 0, 0, 8, 10, 0, 1};
    frm.delete();
    for (int i = 0; i < 16; i++) frm.push_back(DW'(f1[i] + add));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_bit("reset_valid4", vo4, 1'b0);
    chk_val("reset_out4", 0, int'(o4), 0);
    chk_bit("reset_done4", fd4, 1'b0);
    chk_bit("reset_valid24", vo24, 1'b0);
    rst = 1'b0;
    idle(2);
    mon4.delete();
    mon24.delete();

    // 1: contiguous reference frame
    load_f1(0);
    send_frame(1'b0, 4, 4, 0);
    idle(4);
    check_stream(1'b0, "t1");
    chk_val("t1_out_holds", 0, int'(o4), 1);
    chk_bit("t1_valid_low", vo4, 1'b0);

    // 2: three idle cycles between every sample
    load_f1(0);
    send_frame(1'b0, 4, 4, 3);
    idle(4);
    check_stream(1'b0, "t2");

    // 3: saturated frame with one zero per window
    frm.delete();
    for (int i = 0; i < 16; i++) frm.push_back(DW'(20'h7FFFF));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int k;
        k = $urandom_range(3);
        frm[(2*r + k/2)*4 + 2*c + k%2] = '0;
      end
    send_frame(1'b0, 4, 4, 0);
    idle(4);
    check_stream(1'b0, "t3");

    // 4: two frames back to back, B = A + 1
    load_f1(0);
    send_frame(1'b0, 4, 4, 0);
    load_f1(1);
    send_frame(1'b0, 4, 4, 0);
    idle(4);
    check_stream(1'b0, "t4");

    // 5: reset after six samples, then a full clean frame
    load_f1(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v4 = 1'b1;
      d4 = frm[i];
    end
    @(posedge clk);
    #2;
    v4 = 1'b0;
    chk_bit("t5_pre_reset_valid", vo4, 1'b1);
    rst = 1'b1;
    #1;
    chk_bit("t5_reset_valid", vo4, 1'b0);
    chk_val("t5_reset_out", 0, int'(o4), 0);
    chk_bit("t5_reset_done", fd4, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mon4.delete();
    expq.delete();
    send_frame(1'b0, 4, 4, 0);
    idle(4);
    check_stream(1'b0, "t5");

    // 6: default 24x24 random 19-bit frame
    frm.delete();
    for (int i = 0; i < 24 * 24; i++) frm.push_back(DW'($urandom() & 32'h7FFFF));
    send_frame(1'b1, 24, 24, 0);
    idle(4);
    check_stream(1'b1, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
